// File: rtl/imem_loader_if.sv
// Byte-stream handshake feeding the instruction-memory loader.
// The source drives data/valid; the loader answers with ready.
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: byte stream -> 32-bit LE words, holds CPU in reset.
// Optional trailer XOR check enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  imem_loader_if.slave          strm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    WRITE,
    DONE,
    ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif

  localparam logic [16:0] NMAX = 17'(2 ** ADDR_WIDTH);

  state_t state, nxt;

  logic [15:0]           n_q;
  logic [16:0]           wcnt;
  logic [1:0]            bidx;
  logic [WORD_WIDTH-1:0] sreg;
  logic [15:0]           hdr_n;
  logic                  acc;
  logic                  go;
  logic                  last;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign acc   = strm.in_valid & strm.in_ready;
  assign go    = start & ((state == IDLE) | (state == DONE) | (state == ERR));
  assign hdr_n = {strm.in_data, n_q[7:0]};
  assign last  = (wcnt + 17'd1) == {1'b0, n_q};

  assign mem_wdata = sreg;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) nxt = HDR_LO;
      end
      HDR_LO: begin
        if (acc) nxt = HDR_HI;
      end
      HDR_HI: begin
        if (acc) begin
          if (hdr_n == 16'd0)
            nxt = FIN;
          else if ({1'b0, hdr_n} > NMAX)
            nxt = ERR;
          else
            nxt = DATA;
        end
      end
      DATA: begin
        if (acc && bidx == 2'd3) nxt = WRITE;
      end
      WRITE: begin
        nxt = last ? FIN : DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (acc) nxt = (strm.in_data == csum) ? DONE : ERR;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strm.in_ready <= 1'b0;
      mem_we        <= 1'b0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      strm.in_ready <= (nxt == HDR_LO) | (nxt == HDR_HI) | (nxt == DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     | (nxt == CHK)
`endif
                     ;
      mem_we   <= (nxt == WRITE);
      cpu_hold <= (nxt != DONE);
      done     <= (nxt == DONE);
      error    <= (nxt == ERR);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q      <= '0;
      wcnt     <= '0;
      bidx     <= '0;
      sreg     <= '0;
      mem_addr <= '0;
    end else if (go) begin
      wcnt     <= '0;
      bidx     <= '0;
      mem_addr <= '0;
    end else begin
      unique case (state)
        HDR_LO: if (acc) n_q[7:0] <= strm.in_data;
        HDR_HI: if (acc) n_q[15:8] <= strm.in_data;
        DATA: begin
          if (acc) begin
            sreg[{bidx, 3'b000} +: 8] <= strm.in_data;
            bidx <= bidx + 2'd1;
          end
        end
        WRITE: begin
          mem_addr <= mem_addr + 1'b1;
          wcnt     <= wcnt + 17'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum <= '0;
    end else if (go) begin
      csum <= '0;
    end else if (state == DATA && acc) begin
      csum <= csum ^ strm.in_data;
    end
  end
`endif

endmodule
